// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared constants and FSM state encoding for the regfile access controller.
//   DW     data width, equal to the regfile word width
//   AW     register-number width
//   NREG   register count (2**AW)
//   state_t / IDLE, READ_A, READ_B, HOLD : 2-bit operand-fetch FSM states
// Optional feature (in the modules that use this package):
//   `REGACC_BYPASS_EN  forward a same-cycle writeback into operand capture
//                      and into the RAW stall check
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int DW   = 16;
    localparam int AW   = 3;
    localparam int NREG = 8;

    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'd0;
    localparam state_t READ_A = 2'd1;
    localparam state_t READ_B = 2'd2;
    localparam state_t HOLD   = 2'd3;

endpackage

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
// Pending-write scoreboard: one busy bit per register, plus the RAW stall
// check for the two source registers of the request being offered.
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   set_en, set_idx    mark a register busy (accepted request that writes)
//   clr_en, clr_idx    clear a busy bit (writeback)
//   rs_a, rs_b         source registers of the offered request
//   busy               registered busy bits
//   stall              a source register has a write pending
// Macro: `REGACC_BYPASS_EN - a source whose writeback arrives this cycle
//   does not stall (the data is forwarded by the controller).
// -----------------------------------------------------------------------------
module regfile_scoreboard
    import regfile_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            set_en,
    input  logic [AW-1:0]   set_idx,
    input  logic            clr_en,
    input  logic [AW-1:0]   clr_idx,
    input  logic [AW-1:0]   rs_a,
    input  logic [AW-1:0]   rs_b,
    output logic [NREG-1:0] busy,
    output logic            stall
);

    logic [NREG-1:0] busy_reg;
    logic [NREG-1:0] busy_next;

    // Set has priority over clear so a new writer issued in the same cycle
    // as an older writer's writeback keeps the register reserved.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
            assign busy_next[gi] = (set_en && set_idx == AW'(gi)) ? 1'b1 :
                                   (clr_en && clr_idx == AW'(gi)) ? 1'b0 :
                                   busy_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    assign busy = busy_reg;

`ifdef REGACC_BYPASS_EN
    logic fwd_a;
    logic fwd_b;
    assign fwd_a = clr_en && (clr_idx == rs_a);
    assign fwd_b = clr_en && (clr_idx == rs_b);
    assign stall = (busy_reg[rs_a] & ~fwd_a) | (busy_reg[rs_b] & ~fwd_b);
`else
    assign stall = busy_reg[rs_a] | busy_reg[rs_b];
`endif

endmodule

// File: rtl/regfile_access_ctrl.sv
// -----------------------------------------------------------------------------
// regfile_access_ctrl
// Client-side sequencer for a 1R/1W regfile. Fetches two source operands per
// request (one per cycle through the single read port), presents them with a
// valid/ready handshake, passes writebacks straight to the write port, and
// stalls requests whose sources have a pending write.
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   req_valid/req_ready               request handshake
//   req_rs_a, req_rs_b, req_rd, req_wr  request fields
//   op_valid/op_ready                 operand handshake
//   op_a, op_b, op_rd, op_wr          fetched operands and echoed fields
//   wb_valid, wb_num, wb_data         writeback (always accepted)
//   rf_readnum, rf_data_out           regfile read port (combinational read)
//   rf_write, rf_writenum, rf_data_in regfile write port
//   busy                              scoreboard, bit i = write to Ri pending
// Macro: `REGACC_BYPASS_EN - capture wb_data when the writeback targets the
//   register being read this cycle, and let it release a RAW stall.
// -----------------------------------------------------------------------------
module regfile_access_ctrl
    import regfile_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [AW-1:0]   req_rs_a,
    input  logic [AW-1:0]   req_rs_b,
    input  logic [AW-1:0]   req_rd,
    input  logic            req_wr,
    output logic            op_valid,
    input  logic            op_ready,
    output logic [DW-1:0]   op_a,
    output logic [DW-1:0]   op_b,
    output logic [AW-1:0]   op_rd,
    output logic            op_wr,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_num,
    input  logic [DW-1:0]   wb_data,
    output logic [AW-1:0]   rf_readnum,
    input  logic [DW-1:0]   rf_data_out,
    output logic            rf_write,
    output logic [AW-1:0]   rf_writenum,
    output logic [DW-1:0]   rf_data_in,
    output logic [NREG-1:0] busy
);

    state_t          state_reg;
    state_t          state_next;
    logic [AW-1:0]   rs_a_reg;
    logic [AW-1:0]   rs_b_reg;
    logic [AW-1:0]   op_rd_reg;
    logic            op_wr_reg;
    logic [DW-1:0]   op_a_reg;
    logic [DW-1:0]   op_b_reg;
    logic            op_valid_reg;
    logic            stall;
    logic            accept;
    logic [DW-1:0]   read_data;

    assign req_ready = (state_reg == IDLE) & ~stall;
    assign accept    = req_valid & req_ready;

    regfile_scoreboard u_scoreboard (
        .clk     (clk),
        .reset_n (reset_n),
        .set_en  (accept & req_wr),
        .set_idx (req_rd),
        .clr_en  (wb_valid),
        .clr_idx (wb_num),
        .rs_a    (req_rs_a),
        .rs_b    (req_rs_b),
        .busy    (busy),
        .stall   (stall)
    );

    // Read port address: only driven with a real register while fetching.
    always_comb begin
        rf_readnum = '0;
        case (state_reg)
            READ_A:  rf_readnum = rs_a_reg;
            READ_B:  rf_readnum = rs_b_reg;
            default: rf_readnum = '0;
        endcase
    end

`ifdef REGACC_BYPASS_EN
    // The regfile commits a writeback only at the edge, so its output still
    // holds the old value this cycle; take the writeback data directly.
    assign read_data = (wb_valid && (wb_num == rf_readnum)) ? wb_data : rf_data_out;
`else
    assign read_data = rf_data_out;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = READ_A;
            READ_A:  state_next = READ_B;
            READ_B:  state_next = HOLD;
            HOLD:    if (op_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            rs_a_reg     <= '0;
            rs_b_reg     <= '0;
            op_rd_reg    <= '0;
            op_wr_reg    <= 1'b0;
            op_a_reg     <= '0;
            op_b_reg     <= '0;
            op_valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        rs_a_reg  <= req_rs_a;
                        rs_b_reg  <= req_rs_b;
                        op_rd_reg <= req_rd;
                        op_wr_reg <= req_wr;
                    end
                end
                READ_A: begin
                    op_a_reg <= read_data;
                end
                READ_B: begin
                    op_b_reg     <= read_data;
                    op_valid_reg <= 1'b1;
                end
                HOLD: begin
                    if (op_ready) op_valid_reg <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign op_valid = op_valid_reg;
    assign op_a     = op_a_reg;
    assign op_b     = op_b_reg;
    assign op_rd    = op_rd_reg;
    assign op_wr    = op_wr_reg;

    // Writeback pass-through; the write strobe is suppressed during reset.
    assign rf_write    = wb_valid & reset_n;
    assign rf_writenum = wb_num;
    assign rf_data_in  = wb_data;

endmodule
